// File: rtl/dmem_resp_rv32_pkg.sv
// Shared definitions for the RV32I data-memory responder.
// Holds the decoded load/store op codes, the FSM state encoding and the lane helper functions.
package dmem_resp_rv32_pkg;

  localparam logic [9:0] OP_LB  = 10'h001;
  localparam logic [9:0] OP_LH  = 10'h002;
  localparam logic [9:0] OP_LW  = 10'h004;
  localparam logic [9:0] OP_LBU = 10'h008;
  localparam logic [9:0] OP_LHU = 10'h010;
  localparam logic [9:0] OP_SB  = 10'h020;
  localparam logic [9:0] OP_SH  = 10'h040;
  localparam logic [9:0] OP_SW  = 10'h080;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } dmemState_t;

  // Word address is kept apart from this record so its width can follow ADDR_W.
  typedef struct packed {
    logic        rw;
    logic [9:0]  op;
    logic [1:0]  byteOff;
    logic [31:0] wdata;
  } memReq_t;

  // A request is legal only when the op is a load/store, iRW agrees with it, and it is aligned.
  function automatic logic reqLegal(input logic rw, input logic [9:0] op, input logic [1:0] byteOff);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_LB, OP_LBU: ok = rw;
      OP_LH, OP_LHU: ok = rw & ~byteOff[0];
      OP_LW:         ok = rw & (byteOff == 2'b00);
      OP_SB:         ok = ~rw;
      OP_SH:         ok = ~rw & ~byteOff[0];
      OP_SW:         ok = ~rw & (byteOff == 2'b00);
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] storeLanes(input logic [9:0] op, input logic [1:0] byteOff);
    logic [3:0] lanes;
    lanes = 4'b0000;
    case (op)
      OP_SB:   lanes = 4'b0001 << byteOff;
      OP_SH:   lanes = byteOff[1] ? 4'b1100 : 4'b0011;
      OP_SW:   lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

  // Right-aligned store data is replicated so whichever lanes are enabled see the right bytes.
  function automatic logic [31:0] storeData(input logic [9:0] op, input logic [31:0] wdata);
    logic [31:0] d;
    d = wdata;
    case (op)
      OP_SB:   d = {4{wdata[7:0]}};
      OP_SH:   d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] loadExtend(input logic [9:0] op, input logic [1:0] byteOff,
                                             input logic [31:0] q);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (byteOff)
      2'd0:    b = q[7:0];
      2'd1:    b = q[15:8];
      2'd2:    b = q[23:16];
      default: b = q[31:24];
    endcase
    h = byteOff[1] ? q[31:16] : q[15:0];
    r = 32'd0;
    case (op)
      OP_LB:   r = {{24{b[7]}}, b};
      OP_LBU:  r = {24'd0, b};
      OP_LH:   r = {{16{h[15]}}, h};
      OP_LHU:  r = {16'd0, h};
      OP_LW:   r = q;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_resp_rv32_bytelane_ram.sv
// Four byte-wide synchronous-read RAM lanes sharing one word address.
// Contents are deliberately not reset.
module dmem_bytelane_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              iCLK,
  input  logic [ADDR_W-1:0] wordAddr,
  input  logic [3:0]        laneWe,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [7:0] mem [4][2**ADDR_W];

  always_ff @(posedge iCLK) begin
    for (int lane = 0; lane < 4; lane++) begin
      if (laneWe[lane]) begin
        mem[lane][wordAddr] <= wdata[8*lane +: 8];
      end
      rdata[8*lane +: 8] <= mem[lane][wordAddr];
    end
  end

endmodule

// File: rtl/dmem_resp_rv32.sv
// Data-memory responder for the RV32I MA stage: one load/store at a time with programmable
// wait states, byte-lane writes and extended load data; holds the pipeline via oStallD.
module dmem_resp_rv32
  import dmem_resp_rv32_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iMEM,
  input  logic        iRW,
  input  logic [9:0]  iDecodedOP,
  input  logic [31:0] iADDR,
  input  logic [31:0] iWDATA,
  output logic [31:0] oRDATA,
  output logic        oStallD,
  output logic        oACK,
  output logic        oERR
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYC);

  dmemState_t        state, stateNext;
  logic [3:0]        waitCnt, waitCntNext;
  memReq_t           req;
  logic [ADDR_W-1:0] reqWord;
  logic              accept;
  logic              legalNow;
  logic [3:0]        ramWe;
  logic [31:0]       ramQ;
  logic              unusedAddrBits;

  // Upper byte-address bits alias onto the same memory.
  assign unusedAddrBits = ^iADDR[31:ADDR_W+2];
  assign legalNow       = reqLegal(iRW, iDecodedOP, iADDR[1:0]);

  dmem_bytelane_ram #(
    .ADDR_W (ADDR_W)
  ) uRam (
    .iCLK     (iCLK),
    .wordAddr (reqWord),
    .laneWe   (ramWe),
    .wdata    (storeData(req.op, req.wdata)),
    .rdata    (ramQ)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state   <= ST_IDLE;
      waitCnt <= 4'd0;
      req     <= '0;
      reqWord <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      if (accept) begin
        req.rw      <= iRW;
        req.op      <= iDecodedOP;
        req.byteOff <= iADDR[1:0];
        req.wdata   <= iWDATA;
        reqWord     <= iADDR[ADDR_W+1:2];
      end
    end
  end

  // Illegal requests are answered in the same IDLE cycle and never touch the RAM.
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    accept      = 1'b0;
    oStallD     = 1'b0;
    oACK        = 1'b0;
    oERR        = 1'b0;
    oRDATA      = 32'd0;
    ramWe       = 4'b0000;
    case (state)
      ST_IDLE: begin
        if (iMEM) begin
          if (legalNow) begin
            accept      = 1'b1;
            oStallD     = 1'b1;
            waitCntNext = WAIT_INIT;
            stateNext   = (WAIT_CYC == 0) ? ST_ACCESS : ST_WAIT;
          end else begin
            oACK = 1'b1;
            oERR = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        oStallD = 1'b1;
        if (waitCnt <= 4'd1) begin
          stateNext = ST_ACCESS;
        end else begin
          waitCntNext = waitCnt - 4'd1;
        end
      end
      ST_ACCESS: begin
        oStallD   = 1'b1;
        stateNext = ST_DONE;
        // A reset arriving on the write edge must not corrupt memory.
        if (!req.rw && !iRST) begin
          ramWe = storeLanes(req.op, req.byteOff);
        end
      end
      ST_DONE: begin
        oACK      = 1'b1;
        stateNext = ST_IDLE;
        if (req.rw) begin
          oRDATA = loadExtend(req.op, req.byteOff, ramQ);
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_resp_rv32.sv
// Self-checking bench for dmem_resp_rv32: a WAIT_CYC=2 and a WAIT_CYC=0 instance checked
// against a byte-array memory model with directed and randomized loads/stores.
module tb_dmem_resp_rv32;
  import dmem_resp_rv32_pkg::*;

  localparam int MEM_BYTES = 4096;

  logic        iCLK;
  logic        iRST;
  logic        iMEM;
  logic        iRW;
  logic [9:0]  iDecodedOP;
  logic [31:0] iADDR;
  logic [31:0] iWDATA;
  logic        sel;
  logic        memA, memB;
  logic [31:0] rdataA, rdataB;
  logic        stallA, stallB, ackA, ackB, errA, errB;
  logic [31:0] oRDATA;
  logic        oStallD, oACK, oERR;

  int totalChecks = 0;
  int badChecks   = 0;
  int cycleCount  = 0;

  logic [7:0] modelMem [2][MEM_BYTES];

  assign memA    = iMEM & ~sel;
  assign memB    = iMEM & sel;
  assign oRDATA  = sel ? rdataB : rdataA;
  assign oStallD = sel ? stallB : stallA;
  assign oACK    = sel ? ackB : ackA;
  assign oERR    = sel ? errB : errA;

  dmem_resp_rv32 #(.ADDR_W(10), .WAIT_CYC(2)) dutA (
    .iCLK(iCLK), .iRST(iRST), .iMEM(memA), .iRW(iRW), .iDecodedOP(iDecodedOP),
    .iADDR(iADDR), .iWDATA(iWDATA), .oRDATA(rdataA), .oStallD(stallA), .oACK(ackA), .oERR(errA)
  );

  dmem_resp_rv32 #(.ADDR_W(10), .WAIT_CYC(0)) dutB (
    .iCLK(iCLK), .iRST(iRST), .iMEM(memB), .iRW(iRW), .iDecodedOP(iDecodedOP),
    .iADDR(iADDR), .iWDATA(iWDATA), .oRDATA(rdataB), .oStallD(stallB), .oACK(ackB), .oERR(errB)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) cycleCount <= cycleCount + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got still running, expected finished");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    if (obs !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int opSize(input logic [9:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit opIsLoad(input logic [9:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) || (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic bit refLegal(input logic [9:0] op, input logic rw, input logic [31:0] a);
    int sz;
    sz = opSize(op);
    if (sz == 0) return 1'b0;
    return (rw == opIsLoad(op)) && ((int'(a[1:0]) % sz) == 0);
  endfunction

  // Little-endian byte memory; only the low 12 address bits select a byte.
  function automatic logic [31:0] refLoad(input int d, input logic [9:0] op, input logic [31:0] a);
    int          base;
    logic [7:0]  b;
    logic [15:0] h;
    base = int'(a[11:0]);
    b = modelMem[d][base];
    h = {modelMem[d][base+1], modelMem[d][base]};
    case (op)
      OP_LB:   return 32'($signed(b));
      OP_LBU:  return {24'd0, b};
      OP_LH:   return 32'($signed(h));
      OP_LHU:  return {16'd0, h};
      OP_LW:   return {modelMem[d][base+3], modelMem[d][base+2], h};
      default: return 32'd0;
    endcase
  endfunction

  task automatic refStore(input int d, input logic [9:0] op, input logic [31:0] a, input logic [31:0] wd);
    int base;
    base = int'(a[11:0]);
    for (int k = 0; k < opSize(op); k++) begin
      modelMem[d][base+k] = wd[8*k +: 8];
    end
  endtask

  // Issues one request and checks stall, latency, error and data; abortInAccess pulses reset in ACCESS.
  task automatic applyStimulus(input logic [9:0] op, input logic rw, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit abortInAccess,
                               output int ackAt, output logic [31:0] obsData);
    int          w;
    int          d;
    int          cyc;
    bit          legal;
    bit          done;
    logic [31:0] expData;
    d       = sel ? 1 : 0;
    w       = sel ? 0 : 2;
    legal   = refLegal(op, rw, addr);
    expData = (legal && rw) ? refLoad(d, op, addr) : 32'd0;
    ackAt   = -1;
    obsData = 32'd0;
    @(negedge iCLK);
    iMEM = 1'b1; iRW = rw; iDecodedOP = op; iADDR = addr; iWDATA = wdata;
    #1;
    if (!legal) begin
      checkOutput("errAck", 32'(oACK), 32'd1);
      checkOutput("errFlag", 32'(oERR), 32'd1);
      checkOutput("errStall", 32'(oStallD), 32'd0);
      checkOutput("errData", oRDATA, 32'd0);
      ackAt = cycleCount;
      return;
    end
    checkOutput("acceptStall", 32'(oStallD), 32'd1);
    checkOutput("acceptAck", 32'(oACK), 32'd0);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge iCLK);
      cyc++;
      if (abortInAccess && cyc == w + 1) begin
        iRST = 1'b1;
        #1;
        checkOutput("accessStall", 32'(oStallD), 32'd1);
        @(negedge iCLK);
        iRST = 1'b0;
        iMEM = 1'b0;
        #1;
        checkOutput("abortIdle", {30'd0, oStallD, oACK}, 32'd0);
        return;
      end
      #1;
      if (oACK) begin
        done    = 1'b1;
        obsData = oRDATA;
        ackAt   = cycleCount;
        checkOutput("latency", 32'(cyc), 32'(w + 2));
        checkOutput("doneErr", 32'(oERR), 32'd0);
        checkOutput("doneStall", 32'(oStallD), 32'd0);
        checkOutput("doneData", oRDATA, expData);
      end else begin
        checkOutput("busyStall", 32'(oStallD), 32'd1);
      end
    end
    if (!done) begin
      checkOutput("ackTimeout", 32'd0, 32'd1);
      iMEM = 1'b0;
    end else if (!rw) begin
      refStore(d, op, addr, wdata);
    end
  endtask

  function automatic logic [31:0] randHi();
    logic [31:0] r;
    r = $urandom();
    return {r[31:12], 12'h000};
  endfunction

  task automatic idleCycle();
    @(negedge iCLK);
    iMEM = 1'b0;
  endtask

  task automatic initRegion();
    int          unusedAck;
    logic [31:0] unusedData;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(OP_SW, 1'b0, randHi() | 32'(i * 4), $urandom(), 1'b0, unusedAck, unusedData);
    end
  endtask

  task automatic randomPhase(input int n);
    logic [9:0]  ops [8];
    logic [9:0]  op;
    logic        rw;
    int          r;
    int          lo;
    int          sz;
    int          unusedAck;
    logic [31:0] unusedData;
    ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
    for (int i = 0; i < n; i++) begin
      r  = int'($urandom_range(0, 9));
      op = (r < 8) ? ops[r] : ((r == 8) ? 10'h200 : 10'h000);
      rw = opIsLoad(op);
      if ($urandom_range(0, 9) == 0) rw = ~rw;
      lo = int'($urandom_range(0, 255));
      sz = opSize(op);
      if (sz > 1 && $urandom_range(0, 3) != 0) lo = lo & ~(sz - 1);
      applyStimulus(op, rw, randHi() | 32'(lo), $urandom(), 1'b0, unusedAck, unusedData);
      if ($urandom_range(0, 3) == 0) idleCycle();
    end
  endtask

  initial begin
    logic [31:0] obs;
    int          ack1;
    int          ack2;
    int          unusedAck;
    iRST = 1'b1; iMEM = 1'b0; iRW = 1'b0; iDecodedOP = 10'd0; iADDR = 32'd0; iWDATA = 32'd0;
    sel  = 1'b0;
    repeat (2) @(negedge iCLK);
    #1;
    checkOutput("rstStall", 32'(oStallD), 32'd0);
    checkOutput("rstAck", 32'(oACK), 32'd0);
    checkOutput("rstErr", 32'(oERR), 32'd0);
    checkOutput("rstData", oRDATA, 32'd0);
    iRST = 1'b0;

    initRegion();
    applyStimulus(OP_SW, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, unusedAck, obs);
    applyStimulus(OP_LW, 1'b1, 32'h10, 32'd0, 1'b0, unusedAck, obs);
    checkOutput("lwDeadbeef", obs, 32'hDEADBEEF);
    applyStimulus(OP_SB, 1'b0, 32'h13, 32'h00000080, 1'b0, unusedAck, obs);
    applyStimulus(OP_LB, 1'b1, 32'h13, 32'd0, 1'b0, unusedAck, obs);
    checkOutput("lbSign", obs, 32'hFFFFFF80);
    applyStimulus(OP_LBU, 1'b1, 32'h13, 32'd0, 1'b0, unusedAck, obs);
    checkOutput("lbuZero", obs, 32'h00000080);
    applyStimulus(OP_LW, 1'b1, 32'h10, 32'd0, 1'b0, unusedAck, obs);
    checkOutput("lwMerged", obs, 32'h80ADBEEF);
    applyStimulus(OP_SH, 1'b0, 32'h22, 32'h00008001, 1'b0, unusedAck, obs);
    applyStimulus(OP_LH, 1'b1, 32'h22, 32'd0, 1'b0, unusedAck, obs);
    checkOutput("lhSign", obs, 32'hFFFF8001);
    applyStimulus(OP_LHU, 1'b1, 32'h22, 32'd0, 1'b0, unusedAck, obs);
    checkOutput("lhuZero", obs, 32'h00008001);
    applyStimulus(OP_LW, 1'b1, 32'h20, 32'd0, 1'b0, unusedAck, obs);
    checkOutput("lwUpperHalf", {16'd0, obs[31:16]}, 32'h00008001);
    applyStimulus(OP_LW, 1'b1, 32'h11, 32'd0, 1'b0, unusedAck, obs);
    applyStimulus(OP_SH, 1'b0, 32'h21, 32'h0000FFFF, 1'b0, unusedAck, obs);
    applyStimulus(OP_LW, 1'b1, 32'h20, 32'd0, 1'b0, unusedAck, obs);
    checkOutput("lwAfterErr", {16'd0, obs[31:16]}, 32'h00008001);
    applyStimulus(OP_SW, 1'b0, 32'h30, 32'h12345678, 1'b1, unusedAck, obs);
    applyStimulus(OP_LW, 1'b1, 32'h30, 32'd0, 1'b0, unusedAck, obs);
    randomPhase(150);

    idleCycle();
    sel = 1'b1;
    initRegion();
    applyStimulus(OP_SW, 1'b0, 32'h30, 32'h12345678, 1'b1, unusedAck, obs);
    applyStimulus(OP_LW, 1'b1, 32'h30, 32'd0, 1'b0, unusedAck, obs);
    applyStimulus(OP_LW, 1'b1, 32'h40, 32'd0, 1'b0, ack1, obs);
    applyStimulus(OP_LW, 1'b1, 32'h44, 32'd0, 1'b0, ack2, obs);
    checkOutput("b2bSpacing", 32'(ack2 - ack1), 32'd3);
    randomPhase(100);
    idleCycle();

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule
